// File: rtl/if_stage_if.sv
// Instruction-memory port: one outstanding request, completed by a single ack cycle.
interface if_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;

  modport master (output imem_req_o, output imem_addr_o,
                  input  imem_ack_i, input  imem_rdata_i);
  modport slave  (input  imem_req_o, input  imem_addr_o,
                  output imem_ack_i, output imem_rdata_i);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC generation, single-outstanding imem port, {pc,inst} FIFO and
// the IF/ID output register feeding decode.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  if_stage_if.master  imem,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP} state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic          r_req;
  logic [31:0]   r_addr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_mem_pc   [FIFO_DEPTH];
  logic [31:0]   r_mem_inst [FIFO_DEPTH];
  logic [31:0]   r_pc;
  logic [31:0]   r_inst;
  logic          r_valid;

  logic [31:0]   w_new_pc;
  logic [31:0]   w_target;
  logic [31:0]   w_pc_inc;
  logic          w_ack;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_next;
  logic          w_room;
  logic          w_unused_low_bits;

  assign w_new_pc          = {new_pc_i[31:2], 2'b00};
  assign w_unused_low_bits = ^new_pc_i[1:0];
  assign w_target          = flush_i ? w_new_pc : r_fetch_pc;
  assign w_pc_inc          = r_fetch_pc + 32'd4;
  assign w_ack             = r_req & imem.imem_ack_i;
  // Words returning in DROP belong to a fetch that was redirected away.
  assign w_push            = w_ack & (r_state == S_FETCH) & ~flush_i;
  assign w_pop             = ~flush_i & ~stall_i & (r_count != '0);
  assign w_count_next      = flush_i ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
  assign w_room            = (w_count_next < DEPTH_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush_i || (r_count < DEPTH_C)) begin
            r_fetch_pc <= w_target;
            r_addr     <= w_target;
            r_req      <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_ack) begin
            if (flush_i) begin
              r_fetch_pc <= w_new_pc;
              r_addr     <= w_new_pc;
            end else begin
              r_fetch_pc <= w_pc_inc;
              if (w_room) begin
                r_addr <= w_pc_inc;
              end else begin
                r_req   <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end else if (flush_i) begin
            // Request must stay stable until its ack, so wait it out in DROP.
            r_fetch_pc <= w_new_pc;
            r_state    <= S_DROP;
          end
        end
        S_DROP: begin
          if (w_ack) begin
            r_fetch_pc <= w_target;
            if (w_room) begin
              r_addr  <= w_target;
              r_state <= S_FETCH;
            end else begin
              r_req   <= 1'b0;
              r_state <= S_IDLE;
            end
          end else if (flush_i) begin
            r_fetch_pc <= w_new_pc;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= r_addr;
      r_mem_inst[r_wr_ptr] <= imem.imem_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_pc    <= 32'd0;
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end else if (!stall_i) begin
      if (r_count != '0) begin
        r_pc    <= r_mem_pc[r_rd_ptr];
        r_inst  <= r_mem_inst[r_rd_ptr];
        r_valid <= 1'b1;
      end else begin
        r_inst  <= NOP_INST;
        r_valid <= 1'b0;
      end
    end
  end

  assign imem.imem_req_o  = r_req;
  assign imem.imem_addr_o = r_addr;
  assign pc_o             = r_pc;
  assign inst_o           = r_inst;
  assign valid_o          = r_valid;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory model returns addr+0x1000_0000, either zero-wait
// (ack follows req) or with a hand-driven ack.
module tb_if_stage;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] DOFS = 32'h1000_0000;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic        zero_wait;
  logic        man_ack;

  int n_pass  = 0;
  int n_total = 0;

  if_stage_if imem ();

  if_stage dut (
    .clk      (clk),
    .rst      (rst),
    .stall_i  (stall_i),
    .flush_i  (flush_i),
    .new_pc_i (new_pc_i),
    .imem     (imem),
    .pc_o     (pc_o),
    .inst_o   (inst_o),
    .valid_o  (valid_o)
  );

  assign imem.imem_ack_i   = zero_wait ? imem.imem_req_o : man_ack;
  assign imem.imem_rdata_i = imem.imem_addr_o + DOFS;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
      $display("chk %-12s got=%h exp=%h ok", tag, got, exp);
    end else begin
      $display("FAIL %-12s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    stall_i  = 1'b0;
    flush_i  = 1'b0;
    new_pc_i = 32'd0;
    man_ack  = 1'b0;
    step();
    step();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"},   {31'd0, imem.imem_req_o}, 32'd0);
    chk({tag, "_addr"},  imem.imem_addr_o, 32'd0);
    chk({tag, "_pc"},    pc_o, 32'd0);
    chk({tag, "_inst"},  inst_o, NOP);
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
  endtask

  logic        exp_v  [5];
  logic [31:0] exp_pc [5];

  initial begin
    zero_wait = 1'b1;
    man_ack   = 1'b0;
    rst       = 1'b1;
    stall_i   = 1'b0;
    flush_i   = 1'b0;
    new_pc_i  = 32'd0;

    // 1: reset, then zero-wait streaming
    do_reset();
    chk_reset_state("t1_rst");
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t1_addr", imem.imem_addr_o, 32'(4 * (k - 1)));
      chk("t1_req", {31'd0, imem.imem_req_o}, 32'd1);
      if (k == 2) chk("t1_val0", {31'd0, valid_o}, 32'd0);
      if (k >= 3) begin
        chk("t1_pc", pc_o, 32'(4 * (k - 3)));
        chk("t1_inst", inst_o, 32'(4 * (k - 3)) + DOFS);
        chk("t1_valid", {31'd0, valid_o}, 32'd1);
      end
    end

    // 2: stall five cycles, FIFO fills, req drops, then drains in order
    stall_i = 1'b1;
    for (int s = 1; s <= 5; s++) begin
      step();
      chk("t2_hold_pc", pc_o, 32'h0C);
      chk("t2_hold_v", {31'd0, valid_o}, 32'd1);
    end
    chk("t2_req_off", {31'd0, imem.imem_req_o}, 32'd0);
    stall_i = 1'b0;
    exp_v[0] = 1'b1; exp_pc[0] = 32'h10;
    exp_v[1] = 1'b1; exp_pc[1] = 32'h14;
    exp_v[2] = 1'b0; exp_pc[2] = 32'h14;
    exp_v[3] = 1'b1; exp_pc[3] = 32'h18;
    exp_v[4] = 1'b1; exp_pc[4] = 32'h1C;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_valid", {31'd0, valid_o}, {31'd0, exp_v[i]});
      chk("t2_pc", pc_o, exp_pc[i]);
      chk("t2_inst", inst_o, exp_v[i] ? (exp_pc[i] + DOFS) : NOP);
      if (i == 1) begin
        chk("t2_req_on", {31'd0, imem.imem_req_o}, 32'd1);
        chk("t2_addr", imem.imem_addr_o, 32'h18);
      end
    end

    // 3: flush while a slow request is outstanding
    zero_wait = 1'b0;
    do_reset();
    flush_i  = 1'b1;
    new_pc_i = 32'h10;
    rst      = 1'b0;
    step();
    chk("t3_req", {31'd0, imem.imem_req_o}, 32'd1);
    chk("t3_addr", imem.imem_addr_o, 32'h10);
    flush_i = 1'b0;
    step();
    chk("t3_addr_hold", imem.imem_addr_o, 32'h10);
    flush_i  = 1'b1;
    new_pc_i = 32'h203;
    step();
    chk("t3_drop_req", {31'd0, imem.imem_req_o}, 32'd1);
    chk("t3_drop_addr", imem.imem_addr_o, 32'h10);
    flush_i = 1'b0;
    step();
    man_ack = 1'b1;
    step();
    chk("t3_redir", imem.imem_addr_o, 32'h200);
    chk("t3_v_drop", {31'd0, valid_o}, 32'd0);
    step();
    man_ack = 1'b0;
    chk("t3_v_lat", {31'd0, valid_o}, 32'd0);
    chk("t3_next", imem.imem_addr_o, 32'h204);
    step();
    chk("t3_pc", pc_o, 32'h200);
    chk("t3_inst", inst_o, 32'h200 + DOFS);
    chk("t3_valid", {31'd0, valid_o}, 32'd1);

    // 4: flush coincident with ack at 0x8
    zero_wait = 1'b1;
    do_reset();
    rst = 1'b0;
    step(); step(); step();
    flush_i  = 1'b1;
    new_pc_i = 32'h100;
    step();
    flush_i = 1'b0;
    chk("t4_addr", imem.imem_addr_o, 32'h100);
    chk("t4_req", {31'd0, imem.imem_req_o}, 32'd1);
    chk("t4_valid", {31'd0, valid_o}, 32'd0);
    chk("t4_pc", pc_o, 32'd0);
    chk("t4_inst", inst_o, NOP);
    step();
    chk("t4_v2", {31'd0, valid_o}, 32'd0);
    step();
    chk("t4_pc2", pc_o, 32'h100);
    chk("t4_val2", {31'd0, valid_o}, 32'd1);

    // 5: flush and stall together with two entries buffered
    do_reset();
    rst = 1'b0;
    step(); step(); step();
    stall_i = 1'b1;
    step();
    chk("t5_full_req", {31'd0, imem.imem_req_o}, 32'd0);
    chk("t5_hold_pc", pc_o, 32'd0);
    flush_i  = 1'b1;
    new_pc_i = 32'h300;
    step();
    flush_i = 1'b0;
    chk("t5_valid", {31'd0, valid_o}, 32'd0);
    chk("t5_inst", inst_o, NOP);
    chk("t5_pc", pc_o, 32'd0);
    chk("t5_addr", imem.imem_addr_o, 32'h300);
    step();
    chk("t5_v_stall", {31'd0, valid_o}, 32'd0);
    stall_i = 1'b0;
    step();
    chk("t5_pc2", pc_o, 32'h300);
    chk("t5_val2", {31'd0, valid_o}, 32'd1);

    // 6: reset mid-transaction with a buffered entry; late ack ignored
    zero_wait = 1'b0;
    do_reset();
    rst = 1'b0;
    step();
    chk("t6_addr0", imem.imem_addr_o, 32'd0);
    man_ack = 1'b1;
    step();
    chk("t6_addr4", imem.imem_addr_o, 32'h4);
    man_ack = 1'b0;
    stall_i = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk_reset_state("t6_rst");
    rst     = 1'b0;
    stall_i = 1'b0;
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    chk("t6_req", {31'd0, imem.imem_req_o}, 32'd1);
    chk("t6_addr", imem.imem_addr_o, 32'd0);
    chk("t6_valid", {31'd0, valid_o}, 32'd0);
    step();
    chk("t6_valid2", {31'd0, valid_o}, 32'd0);
    chk("t6_addr2", imem.imem_addr_o, 32'd0);

    // 7: PC wraps from 0xFFFF_FFFC to 0
    zero_wait = 1'b1;
    do_reset();
    flush_i  = 1'b1;
    new_pc_i = 32'hFFFF_FFF8;
    rst      = 1'b0;
    step();
    flush_i = 1'b0;
    chk("t7_a0", imem.imem_addr_o, 32'hFFFF_FFF8);
    step();
    chk("t7_a1", imem.imem_addr_o, 32'hFFFF_FFFC);
    step();
    chk("t7_wrap", imem.imem_addr_o, 32'd0);
    chk("t7_pc0", pc_o, 32'hFFFF_FFF8);
    step();
    chk("t7_pc1", pc_o, 32'hFFFF_FFFC);
    chk("t7_inst1", inst_o, 32'h0FFF_FFFC);
    step();
    chk("t7_pc2", pc_o, 32'd0);
    chk("t7_val2", {31'd0, valid_o}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
